// File: rtl/fifo_nd_downsize_pkg.sv
// Shared helpers for the width-converting FIFOs: constant clog2 and slice selection.
package fifo_nd_downsize_pkg;

    // Widest word the slice helper can carry; callers zero-extend into it.
    localparam int unsigned SLICE_MAX_W = 1024;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) result++;
        return result;
    endfunction

    // Returns the word shifted so the selected slice sits at bit 0.
    function automatic logic [SLICE_MAX_W-1:0] slice_sel(
        input logic [SLICE_MAX_W-1:0] word,
        input int unsigned            in_w,
        input int unsigned            out_w,
        input int unsigned            index,
        input logic                   msb_first
    );
        int unsigned lsb;
        lsb = msb_first ? (in_w - out_w * (index + 1)) : (out_w * index);
        return word >> lsb;
    endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Circular-buffer bookkeeping: read/write pointers, occupancy level, full/empty.
module fifo_ptr_ctrl
    import fifo_nd_downsize_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PW    = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1,
    localparam int unsigned LW    = clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    output logic [PW-1:0] wr_ptr,
    output logic [PW-1:0] rd_ptr,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (rst || flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = bump(wr_ptr_q);
            if (pop)  rd_ptr_d = bump(rd_ptr_q);
            if (push && !pop)      level_d = level_q + LW'(1);
            else if (pop && !push) level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        level_q  <= level_d;
    end

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign level  = level_q;
    assign full   = (level_q == LW'(DEPTH));
    assign empty  = (level_q == '0);

endmodule

// File: rtl/fifo_nd_downsize.sv
// Width-downsizing FIFO: IN_W-bit words out as up to RATIO slices of IN_W/RATIO bits.
module fifo_nd_downsize
    import fifo_nd_downsize_pkg::*;
#(
    parameter  int unsigned IN_W      = 64,
    parameter  int unsigned RATIO     = 2,
    parameter  int unsigned DEPTH     = 2,
    parameter  int unsigned MSB_FIRST = 1,
    localparam int unsigned OUT_W     = IN_W / RATIO,
    localparam int unsigned CW        = (clog2(RATIO) > 1) ? clog2(RATIO) : 1,
    localparam int unsigned LW        = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [IN_W-1:0]  a_data,
    input  logic [CW-1:0]    a_nbeats,
    input  logic             a_valid,
    output logic             a_ready,
    output logic [OUT_W-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic             b_last,
    output logic [LW-1:0]    level
);

    localparam int unsigned PW = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;

    typedef struct packed {
        logic [IN_W-1:0] data;
        logic [CW-1:0]   nbeats;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [CW-1:0] idx_q, idx_d;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          full, empty;
    logic          push, slice_pop, word_pop;
    entry_t        head;

    assign head = mem_q[rd_ptr];

    always_comb begin
        b_valid   = !empty;
        b_last    = b_valid && (idx_q == head.nbeats);
        b_data    = OUT_W'(slice_sel(SLICE_MAX_W'(head.data), IN_W, OUT_W,
                                     32'(idx_q), MSB_FIRST != 0));
        slice_pop = b_valid && b_ready;
        word_pop  = slice_pop && b_last;
        // Full buffer still accepts when the head word leaves this cycle.
        a_ready   = !full || word_pop;
        push      = a_valid && a_ready;

        idx_d = idx_q;
        if (rst || flush)   idx_d = '0;
        else if (word_pop)  idx_d = '0;
        else if (slice_pop) idx_d = idx_q + CW'(1);

        mem_d = mem_q;
        if (push && !rst && !flush) mem_d[wr_ptr] = '{data: a_data, nbeats: a_nbeats};
    end

    always_ff @(posedge clk) begin
        idx_q <= idx_d;
        mem_q <= mem_d;
    end

    fifo_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .push   (push),
        .pop    (word_pop),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .level  (level),
        .full   (full),
        .empty  (empty)
    );

    always_ff @(posedge clk) begin
        if (!rst && push) assert (32'(a_nbeats) <= RATIO - 1);
    end

endmodule

// File: doc/fifo_nd_downsize.md
Name: fifo_nd_downsize

Overview:
Parametrised width-downsizing FIFO. It accepts IN_W-bit words on a valid/ready port and emits them as RATIO narrower slices of OUT_W = IN_W/RATIO bits. It supersedes the fixed 64-to-32 single-entry converter:
- configurable depth
- configurable slice order
- per-word partial beat count
- synchronous flush

Typical use: instruction fetch and memory return paths feeding 32-bit or 16-bit consumers.

Parameters:
IN_W, 64, input word width; must be divisible by RATIO.
RATIO, 2, slices per word; must be >= 2.
DEPTH, 2, storage entries in IN_W words; must be >= 1.
MSB_FIRST, 1, 1 = first slice is bits [IN_W-1 -: OUT_W]; 0 = first slice is bits [OUT_W-1:0].
(Derived locally: OUT_W = IN_W/RATIO, CW = max(1, clog2(RATIO)), LW = clog2(DEPTH+1).)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  synchronous discard of all contents
a_data  in  IN_W  input word
a_nbeats  in  CW  number of valid slices in the word, minus 1 (RATIO-1 = full word)
a_valid  in  1  input word valid
a_ready  out  1  input can accept this cycle
b_data  out  OUT_W  current output slice
b_valid  out  1  output slice valid
b_ready  in  1  consumer accepts slice
b_last  out  1  current slice is the final valid slice of its word
level  out  LW  number of words held, counting a partially consumed head

Behaviour:
- Reset (rst=1 at a clock edge):
  - Clears write pointer, read pointer, level and slice index to 0.
  - Afterwards b_valid=0, b_last=0, a_ready=1, level=0.
  - Storage is not reset; b_data is don't-care while b_valid=0.
  - rst has priority over flush and over any handshake in the same cycle. Mid-word reset discards the remaining slices.
- Flush (flush=1, rst=0): same state effect as reset. Any push or pop in that cycle is discarded and not counted.
- Storage: circular buffer of DEPTH entries. Each entry holds {data, nbeats}. Pointers wrap from DEPTH-1 to 0 and need not be a power of two.
- Push = a_valid & a_ready. The word is written at wr_ptr and wr_ptr advances.
- Pop-slice = b_valid & b_ready:
  - If slice index == head nbeats, this is a word pop: slice index returns to 0 and rd_ptr advances.
  - Otherwise slice index increments.
- Output:
  - b_valid = (level != 0).
  - b_data = head slice at the current index, selected per MSB_FIRST.
  - b_last = b_valid & (index == head nbeats).
- Latency: a word accepted at edge N is visible on b_* after edge N (one cycle). There is no combinational a->b bypass.
- a_ready = (level < DEPTH) | (b_valid & b_ready & b_last). When full, the buffer accepts a new word in the same cycle as the final-slice pop, so level stays DEPTH.
- a_ready does not depend on a_valid. b_valid does not depend on b_ready.
- Simultaneous push and word pop: level is unchanged.
  - Push only: level+1.
  - Word pop only: level-1.
  - Non-final slice pop: level is unchanged.
- a_nbeats = 0 gives a one-slice word: b_last=1 on its first slice.
- With DEPTH=1, RATIO=2, MSB_FIRST=1, all nbeats=1, the behaviour is cycle-identical to the legacy 64-to-32 converter.
- Protocol rules:
  - a_data and a_nbeats are sampled only on push.
  - Values of a_nbeats > RATIO-1 are illegal and asserted against in simulation.

Decomposition:
- Shared package holds the slice-select helper function (word, index, MSB_FIRST -> slice) and the clog2 helper. The upsizing counterpart will use both.
- No typedefs are needed beyond the entry record {data, nbeats}, declared locally.
- One natural sub-module, fifo_ptr_ctrl: pointers, level, full/empty, and wrap for non-power-of-two DEPTH. It is reusable by the upsizer.

Test Plan:
1. Reset then single word: defaults, push a_data=64'h1122334455667788 with a_nbeats=1 and b_ready=1 held.
   -> b_data=32'h11223344 (b_last=0), then 32'h55667788 (b_last=1), then b_valid=0. level goes 1, 1, 0.
2. Fill and backpressure: DEPTH=2, b_ready=0, push 3 words.
   -> a_ready=0 after 2 pushes, level=2. Raise b_ready.
   -> a_ready=1 only in the final-slice cycle of the head word; the third word is accepted there and level stays 2.
3. Partial words: push A with nbeats=0, then B with nbeats=1, b_ready=1.
   -> A emits 1 slice with b_last=1, then B emits 2 slices. No bubble between A and B.
4. LSB-first, RATIO=4, IN_W=64: push 64'h0123456789ABCDEF.
   -> 16'hCDEF, 16'h89AB, 16'h4567, 16'h0123; b_last on the 4th.
5. Flush and reset mid-word: after the first slice of a word, assert flush.
   -> next cycle b_valid=0, level=0, and the following push starts at slice 0.
   Repeat with rst and with flush asserted concurrently with a push -> the push is dropped.
6. Random stress: random a_valid, b_ready and nbeats for 10k cycles against a scoreboard.
   -> every valid slice is delivered in order, and level never exceeds DEPTH.
